// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, followed by a single sign-fix cycle that loads HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oper_A,
  input  logic [WIDTH-1:0] oper_B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, sq_q, sr_q, dz_q;
  logic [WIDTH-1:0] mcand_q;   // multiplicand or divisor
  logic [WIDTH-1:0] acc_q;     // product high half or partial remainder
  logic [WIDTH-1:0] low_q;     // multiplier/product low half or dividend/quotient
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             signed_op, s_a, s_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub, rem_d, quo_d;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and sign flags; 0x80000000 maps to itself as unsigned.
  always_comb begin
    signed_op = ~op[0];
    s_a       = signed_op & oper_A[WIDTH-1];
    s_b       = signed_op & oper_B[WIDTH-1];
    mag_a     = s_a ? (~oper_A + WIDTH'(1)) : oper_A;
    mag_b     = s_b ? (~oper_B + WIDTH'(1)) : oper_B;
  end

  // One iteration step for each operation, and the sign-corrected results.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + {1'b0, (low_q[0] ? mcand_q : WIDTH'(0))};
    rem_sh   = {acc_q, low_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, mcand_q});
    rem_sub  = WIDTH'(rem_sh - {1'b0, mcand_q});
    rem_d    = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    quo_d    = {low_q[WIDTH-2:0], rem_ge};
    prod_fix = sq_q ? (~{acc_q, low_q} + PW'(1)) : {acc_q, low_q};
    quo_fix  = sq_q ? (~low_q + WIDTH'(1)) : low_q;
    rem_fix  = sr_q ? (~acc_q + WIDTH'(1)) : acc_q;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      dz_q       <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      low_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            cnt_q      <= CW'(WIDTH - 1);
            is_div_q   <= op[1];
            sq_q       <= s_a ^ s_b;
            sr_q       <= s_a;
            dz_q       <= op[1] & (oper_B == '0);
            div_zero_q <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= op[1] ? mag_b : mag_a;
            low_q      <= op[1] ? mag_a : mag_b;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (is_div_q) begin
            acc_q <= rem_d;
            low_q <= quo_d;
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            low_q <= {mul_sum[0], low_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[PW-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          div_zero_q <= dz_q;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, divide-by-zero, ignored
// start, back-to-back issue and asynchronous reset abort.
module tb_muldiv_sequencer;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic         Clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] oper_A, oper_B;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op),
    .oper_A(oper_A), .oper_B(oper_B),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive start for exactly one sampling edge; check the accept edge effects.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    start = 1'b1; op = o; oper_A = a; oper_B = b;
    @(posedge Clk); #1;
    t0 = cyc;
    start = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_done", 64'(done), 64'd0);
    check("accept_dz_clear", 64'(div_zero), 64'd0);
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input logic exp_dz);
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1;
      if (done) break;
    end
    check({tag, "_latency"}, 64'(cyc - t0), 64'(LAT));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ndone;
    start = 1'b0; op = 2'b00; oper_A = '0; oper_B = '0;
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) reset = 1'b1;

    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    start_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_minmin", 32'h4000_0000, 32'h0000_0000, 1'b0);

    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    start_op(2'b11, 32'd100, 32'd7);
    wait_done("divu", 32'd2, 32'd14, 1'b0);

    start_op(2'b11, 32'd5, 32'd0);
    wait_done("divu_zero", 32'd5, 32'hFFFF_FFFF, 1'b1);
    @(posedge Clk); #1;
    check("dz_held", 64'(div_zero), 64'd1);

    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);

    start_op(2'b10, 32'h8000_0000, 32'd0);
    wait_done("div_zero_s", 32'h8000_0000, 32'h0000_0001, 1'b1);

    // Start mid-operation must be ignored entirely.
    start_op(2'b01, 32'd6, 32'd7);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    start = 1'b1; op = 2'b11; oper_A = 32'd9; oper_B = 32'd3;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_done("ignored", 32'd0, 32'd42, 1'b0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (done) ndone++;
    end
    check("no_second_done", 64'(ndone), 64'd0);
    check("hold_lo", 64'(lo), 64'd42);

    // Back-to-back: issue during the done cycle.
    start_op(2'b11, 32'd100, 32'd7);
    wait_done("b2b_first", 32'd2, 32'd14, 1'b0);
    start_op(2'b01, 32'd1000, 32'd1000);
    check("b2b_hold_hi", 64'(hi), 64'd2);
    check("b2b_hold_lo", 64'(lo), 64'd14);
    wait_done("b2b_second", 32'd0, 32'd1_000_000, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    start_op(2'b00, 32'd123, 32'd456);
    repeat (14) @(posedge Clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge Clk) reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("abort_idle", 64'(busy), 64'd0);
    start_op(2'b01, 32'd3, 32'd5);
    wait_done("after_rst", 32'd0, 32'd15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
